// File: rtl/twenty_bit_operand_regfile.sv
// Operand register file feeding the 20-bit logic units: 16 entries, two
// registered read ports with same-cycle write-to-read bypass.

module twenty_bit_operand_regfile_port #(
  parameter int DATA_W   = 20,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 rd_en,
  input  logic [ADDR_W-1:0]                    addr,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]   mem,
  input  logic                                 wr_en,
  input  logic [ADDR_W-1:0]                    wr_addr,
  input  logic [DATA_W-1:0]                    wr_data,
  output logic [DATA_W-1:0]                    op
);

  logic [DATA_W-1:0] value;

  // Hardwired zero wins over bypass so a discarded r0 write never leaks out.
  always_comb begin
    value = mem[addr];
    if (ZERO_REG != 0 && addr == '0)
      value = '0;
    else if (wr_en && wr_addr == addr)
      value = wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      op <= '0;
    else if (rd_en)
      op <= value;
  end

endmodule

module twenty_bit_operand_regfile #(
  parameter int DATA_W   = 20,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              op_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int DEPTH     = 2**ADDR_W;
  localparam int NUM_PORTS = 2;

  logic [DEPTH-1:0][DATA_W-1:0]     mem;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] op;
  logic                             wr_ok;

  assign wr_ok   = wr_en && !(ZERO_REG != 0 && wr_addr == '0);
  assign rd_addr = {rd_addr_b, rd_addr_a};
  assign op_a    = op[0];
  assign op_b    = op[1];

  always_ff @(posedge clk) begin
    if (!rst_n)
      mem <= '0;
    else if (wr_ok)
      mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      op_valid <= 1'b0;
    else
      op_valid <= rd_en;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    twenty_bit_operand_regfile_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_port (
      .clk    (clk),
      .rst_n  (rst_n),
      .rd_en  (rd_en),
      .addr   (rd_addr[p]),
      .mem    (mem),
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .op     (op[p])
    );
  end

endmodule

// File: tb/tb_twenty_bit_operand_regfile.sv
// Scoreboard bench: stimulus pushes per-edge expectations from a reference
// model, an independent monitor pops and compares on the falling edge.

module tb_twenty_bit_operand_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en;
  logic [3:0]  rd_addr_a, rd_addr_b;
  logic [19:0] op_a, op_b;
  logic        op_valid;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [19:0] wr_data;

  int errors = 0;
  int checks = 0;
  bit done   = 1'b0;

  typedef struct packed {
    logic        v;
    logic [19:0] a;
    logic [19:0] b;
  } exp_t;

  exp_t        q[$];
  logic [19:0] rm [16];
  logic [19:0] ea = '0, eb = '0;
  logic        ev = 1'b0;

  always #5 clk = ~clk;

  twenty_bit_operand_regfile #(.DATA_W(20), .ADDR_W(4), .ZERO_REG(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_en),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_valid (op_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  function automatic logic [19:0] ref_val(input logic [3:0] x);
    if (x == 4'd0) return 20'h0;
    if (wr_en && wr_addr == x) return wr_data;
    return rm[x];
  endfunction

  task automatic cyc(input logic r, input logic [3:0] ra, input logic [3:0] rb,
                     input logic wen, input logic [3:0] wa, input logic [19:0] wd,
                     input logic rs);
    exp_t e;
    rd_en = r; rd_addr_a = ra; rd_addr_b = rb;
    wr_en = wen; wr_addr = wa; wr_data = wd; rst_n = rs;
    if (!rs) begin
      foreach (rm[i]) rm[i] = '0;
      ea = '0; eb = '0; ev = 1'b0;
    end else begin
      if (r) begin
        ea = ref_val(ra);
        eb = ref_val(rb);
        ev = 1'b1;
      end else begin
        ev = 1'b0;
      end
      if (wen && wa != 4'd0) rm[wa] = wd;
    end
    e.v = ev; e.a = ea; e.b = eb;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expectation per rising edge, compared half a cycle later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      @(negedge clk);
      if (done) break;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at %0t: no expectation queued", $time);
      end else begin
        e = q.pop_front();
        if (op_valid !== e.v || op_a !== e.a || op_b !== e.b) begin
          errors++;
          $display("FAIL ops at %0t: got v=%0b a=%05h b=%05h required v=%0b a=%05h b=%05h",
                   $time, op_valid, op_a, op_b, e.v, e.a, e.b);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [19:0] andv;
    foreach (rm[i]) rm[i] = '0;
    // Reset clear with write/read asserted under reset
    cyc(1, 3, 3, 1, 3, 20'hFFFFF, 0);
    cyc(1, 3, 3, 1, 3, 20'hFFFFF, 0);
    cyc(1, 3, 3, 0, 0, 20'h0, 1);
    // Write then read
    cyc(0, 0, 0, 1, 1, 20'h0005F, 1);
    cyc(0, 0, 0, 1, 2, 20'hC0003, 1);
    cyc(1, 1, 2, 0, 0, 20'h0, 1);
    andv = op_a & op_b;
    checks++;
    if (andv !== 20'h00003) begin
      errors++;
      $display("FAIL and_result: got %05h required 00003", andv);
    end
    // Bypass, then plain read of the written register
    cyc(1, 5, 4, 1, 5, 20'hFFFFF, 1);
    cyc(1, 5, 5, 0, 0, 20'h0, 1);
    // Equal addresses both bypassed
    cyc(1, 7, 7, 1, 7, 20'h5A5A5, 1);
    // Zero register
    cyc(0, 0, 0, 1, 0, 20'h12345, 1);
    cyc(1, 0, 0, 1, 0, 20'hABCDE, 1);
    // Idle hold and valid drop
    cyc(1, 1, 2, 0, 0, 20'h0, 1);
    repeat (3) cyc(0, 9, 10, 0, 0, 20'h0, 1);
    // Read/write to different addresses: old contents returned
    cyc(1, 1, 2, 1, 3, 20'h33333, 1);
    cyc(1, 3, 1, 0, 0, 20'h0, 1);
    // Mid-operation reset
    cyc(1, 1, 2, 0, 0, 20'h0, 1);
    cyc(1, 2, 1, 0, 0, 20'h0, 1);
    cyc(1, 1, 1, 0, 0, 20'h0, 0);
    cyc(1, 1, 1, 0, 0, 20'h0, 1);
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
          1'($urandom_range(0, 2) != 0), 4'($urandom), 20'($urandom),
          1'($urandom_range(0, 63) != 0));
    end
    @(negedge clk);
    #1;
    done = 1'b1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
